// File: rtl/wb_stage.sv
// Writeback stage: result-source select, load extract/extend, wait-for-memory FSM, registered RF write port.
// Optional macro WB_FWD_EN adds a combinational forwarding port taken from the registered write.
module wb_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_4,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] imm,
  input  logic [1:0]      wb_sel,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [RAW-1:0]  rd_addr,
  input  logic            rd_we,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  input  logic            flush,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            ld_err
`ifdef WB_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [RAW-1:0]  fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam bit IS64 = (XLEN == 64);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [RAW-1:0]    hold_rd_reg, hold_rd_next;
  logic              hold_we_reg, hold_we_next;
  logic [2:0]        hold_f3_reg, hold_f3_next;
  logic [1:0]        hold_off_reg, hold_off_next;
  logic              rf_we_reg, rf_we_next;
  logic [RAW-1:0]    rf_waddr_reg, rf_waddr_next;
  logic [XLEN-1:0]   rf_wdata_reg, rf_wdata_next;
  logic              ld_err_reg, ld_err_next;

  logic              accept;
  logic              is_load;
  logic [2:0]        sel_f3;
  logic [1:0]        sel_off;
  logic [RAW-1:0]    op_rd;
  logic              op_we;
  logic [XLEN-1:0]   src_data;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ld_data;
  logic              ld_illegal;
  logic [XLEN-1:0]   shift_cand [4];

  assign in_ready = (state_reg == S_IDLE);
  assign accept   = in_valid && in_ready && !flush;
  assign is_load  = (wb_sel == 2'b10);

  // In WAIT the load is described by the captured fields, not by the live inputs.
  assign sel_f3  = (state_reg == S_WAIT) ? hold_f3_reg  : ld_funct3;
  assign sel_off = (state_reg == S_WAIT) ? hold_off_reg : ld_off;
  assign op_rd   = (state_reg == S_WAIT) ? hold_rd_reg  : rd_addr;
  assign op_we   = (state_reg == S_WAIT) ? hold_we_reg  : rd_we;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shift
      assign shift_cand[gi] = mem_rdata >> (8 * gi);
    end
  endgenerate

  assign shifted = shift_cand[sel_off];

  always_comb begin
    src_data = alu;
    case (wb_sel)
      2'b00:   src_data = pc_4;
      2'b01:   src_data = alu;
      2'b11:   src_data = imm;
      default: src_data = alu;
    endcase
  end

  always_comb begin
    ld_data    = '0;
    ld_illegal = 1'b0;
    case (sel_f3)
      3'b000: ld_data = XLEN'($signed(shifted[7:0]));
      3'b001: ld_data = XLEN'($signed(shifted[15:0]));
      3'b010: ld_data = XLEN'($signed(shifted[31:0]));
      3'b100: ld_data = XLEN'(shifted[7:0]);
      3'b101: ld_data = XLEN'(shifted[15:0]);
      3'b011: begin
        if (IS64) ld_data = shifted;
        else      ld_illegal = 1'b1;
      end
      3'b110: begin
        if (IS64) ld_data = XLEN'(shifted[31:0]);
        else      ld_illegal = 1'b1;
      end
      default: ld_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    hold_rd_next  = hold_rd_reg;
    hold_we_next  = hold_we_reg;
    hold_f3_next  = hold_f3_reg;
    hold_off_next = hold_off_reg;
    rf_we_next    = 1'b0;
    ld_err_next   = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (!is_load) begin
            if (rd_we && (rd_addr != '0)) begin
              rf_we_next    = 1'b1;
              rf_waddr_next = rd_addr;
              rf_wdata_next = src_data;
            end
          end else if (mem_rvalid) begin
            if (ld_illegal) begin
              ld_err_next = 1'b1;
            end else if (op_we && (op_rd != '0)) begin
              rf_we_next    = 1'b1;
              rf_waddr_next = op_rd;
              rf_wdata_next = ld_data;
            end
          end else begin
            state_next    = S_WAIT;
            hold_rd_next  = rd_addr;
            hold_we_next  = rd_we;
            hold_f3_next  = ld_funct3;
            hold_off_next = ld_off;
          end
        end
      end
      S_WAIT: begin
        // flush wins over a same-cycle mem_rvalid
        if (flush) begin
          state_next = S_IDLE;
        end else if (mem_rvalid) begin
          state_next = S_IDLE;
          if (ld_illegal) begin
            ld_err_next = 1'b1;
          end else if (op_we && (op_rd != '0)) begin
            rf_we_next    = 1'b1;
            rf_waddr_next = op_rd;
            rf_wdata_next = ld_data;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      hold_rd_reg  <= '0;
      hold_we_reg  <= 1'b0;
      hold_f3_reg  <= '0;
      hold_off_reg <= '0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      ld_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_rd_reg  <= hold_rd_next;
      hold_we_reg  <= hold_we_next;
      hold_f3_reg  <= hold_f3_next;
      hold_off_reg <= hold_off_next;
      rf_we_reg    <= rf_we_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
      ld_err_reg   <= ld_err_next;
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign ld_err   = ld_err_reg;

`ifdef WB_FWD_EN
  assign fwd_valid = rf_we_reg && (rf_waddr_reg != '0);
  assign fwd_rd    = rf_waddr_reg;
  assign fwd_data  = rf_wdata_reg;
`endif

endmodule
